// File: rtl/cpu_pkg.sv
// Shared types for the fetch slice: bus widths, fetch FSM states and the
// {instr, pc} record carried by the prefetch buffer.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch bus: instruction-memory address/data plus the valid/ready channel
// toward decode.
//   master (fetch side): drives imem_addr, out_valid, out_instr, out_pc;
//                        receives imem_instr, out_ready
//   slave  (memory/decode side): the mirror image
interface instr_fetch_ctrl_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, out_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Prefetch buffer: {instr, pc} FIFO with flush. The head entry always sits
// in slot 0 so the outputs come straight from flops; DEPTH=1 collapses to a
// single register.
// Ports: clk, rst (sync, active-low), flush, push/din, pop,
//        head (entry at slot 0), valid (non-empty), count (occupancy).
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 din,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH == 1) begin : g_reg
    // Single holding register; push and pop together replaces the entry.
    always_ff @(posedge clk) begin
      if (!rst) begin
        head  <= '0;
        count <= '0;
        valid <= 1'b0;
      end else if (flush) begin
        count <= '0;
        valid <= 1'b0;
      end else if (push) begin
        head  <= din;
        count <= CNT_W'(1);
        valid <= 1'b1;
      end else if (pop) begin
        count <= '0;
        valid <= 1'b0;
      end
    end
  end else begin : g_fifo
    fetch_entry_t     ent [DEPTH];
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] cnt_nxt;

    // Write slot is computed after the pop has shifted everything down.
    always_comb begin
      wr_idx  = count - CNT_W'(pop);
      cnt_nxt = wr_idx + CNT_W'(push);
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < int'(DEPTH); i++) ent[i] <= '0;
        count <= '0;
        valid <= 1'b0;
      end else if (flush) begin
        count <= '0;
        valid <= 1'b0;
      end else begin
        if (pop) begin
          for (int i = 0; i < int'(DEPTH) - 1; i++) ent[i] <= ent[i+1];
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (push && wr_idx == CNT_W'(i)) ent[i] <= din;
        end
        count <= cnt_nxt;
        valid <= (cnt_nxt != '0);
      end
    end

    assign head = ent[0];
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues word fetches to instruction memory,
// buffers responses for decode, and handles branch redirect and halt.
// Build option: IFETCH_PREFETCH_BUF_EN selects a 2-entry prefetch buffer
// (back-to-back delivery); otherwise a single holding register is used.
// Ports: clk, rst (sync, active-low), start, halt, redirect_valid,
//        redirect_pc, busy (high while fetching), bus (master side of the
//        imem address/data and decode valid/ready channel).
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  instr_fetch_ctrl_if.master bus
);

`ifdef IFETCH_PREFETCH_BUF_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              in_flight;

  logic              flush_c;
  logic              pop_c;
  logic              push_c;
  logic              issue_c;
  logic [OCC_W-1:0]  occ_c;
  fetch_entry_t      cap_c;

  fetch_entry_t      head;
  logic              buf_valid;
  logic [CNT_W-1:0]  buf_count;

  // Issue only if buffer + in-flight + new fetch still fit after this
  // cycle's transfer; a flush suppresses both capture and issue.
  always_comb begin
    flush_c     = (state == FETCH) && (halt || redirect_valid);
    pop_c       = buf_valid && bus.out_ready;
    push_c      = in_flight && !flush_c;
    occ_c       = OCC_W'(buf_count) + OCC_W'(in_flight) - OCC_W'(pop_c);
    issue_c     = (state == FETCH) && !flush_c && (occ_c < OCC_W'(DEPTH));
    cap_c.instr = bus.imem_instr;
    cap_c.pc    = bus.imem_addr;
  end

  // Fetch FSM, PC and memory address; halt takes priority over redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      bus.imem_addr <= RESET_PC;
      in_flight     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          in_flight <= 1'b0;
          if (start) begin
            state <= FETCH;
            pc    <= RESET_PC;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (halt) begin
            state     <= HALTED;
            in_flight <= 1'b0;
            busy      <= 1'b0;
          end else if (redirect_valid) begin
            pc        <= redirect_pc;
            in_flight <= 1'b0;
          end else begin
            in_flight <= issue_c;
            if (issue_c) begin
              bus.imem_addr <= pc;
              pc            <= pc + ADDR_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_flight <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_c),
    .push  (push_c),
    .din   (cap_c),
    .pop   (pop_c),
    .head  (head),
    .valid (buf_valid),
    .count (buf_count)
  );

  assign bus.out_valid = buf_valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: cycle table for start/stream/halt, directed
// stall, redirect, wrap and mid-stream reset sequences, then a randomized
// run checked against a transaction-level model of the delivered PC stream.
module tb_instr_fetch_ctrl;
  import cpu_pkg::*;

`ifdef IFETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        start0 = 1'b0, halt0 = 1'b0, redir0 = 1'b0, ready0 = 1'b0;
  logic [15:0] rpc0 = '0;
  logic        busy0;
  logic        start1 = 1'b0, ready1 = 1'b0;
  logic        busy1;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  instr_fetch_ctrl_if bus0 ();
  instr_fetch_ctrl_if bus1 ();

  assign bus0.imem_instr = memf(bus0.imem_addr);
  assign bus0.out_ready  = ready0;
  assign bus1.imem_instr = memf(bus1.imem_addr);
  assign bus1.out_ready  = ready1;

  instr_fetch_ctrl #(.RESET_PC(16'h0000)) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .start          (start0),
    .halt           (halt0),
    .redirect_valid (redir0),
    .redirect_pc    (rpc0),
    .busy           (busy0),
    .bus            (bus0)
  );

  instr_fetch_ctrl #(.RESET_PC(16'hFFFE)) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .start          (start1),
    .halt           (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (16'h0000),
    .busy           (busy1),
    .bus            (bus1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start0 = 0; halt0 = 0; redir0 = 0; ready0 = 0; start1 = 0; ready1 = 0;
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        start, halt, redir, ready;
    logic [15:0] rpc;
    logic        ev, eb;
    logic [15:0] epc, ea;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic h, input logic r, input logic rd,
                              input logic [15:0] rpc, input logic ev, input logic eb,
                              input logic [15:0] epc, input logic [15:0] ea);
    vec_t v;
    v.start = s; v.halt = h; v.redir = r; v.ready = rd; v.rpc = rpc;
    v.ev = ev; v.eb = eb; v.epc = epc; v.ea = ea;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    int n;
    logic found;
    logic [15:0] exp1 [4];

    // ---------------- reset values
    rst = 1'b0;
    step();
    step();
    chk("rst_valid", 16'(bus0.out_valid), 16'h0);
    chk("rst_instr", bus0.out_instr, 16'h0);
    chk("rst_pc",    bus0.out_pc,    16'h0);
    chk("rst_busy",  16'(busy0),     16'h0);
    chk("rst_addr",  bus0.imem_addr, 16'h0000);
    chk("rst_addr1", bus1.imem_addr, 16'hFFFE);
    rst = 1'b1;

    // ---------------- table: start, stream, halt+redirect, restart
`ifdef IFETCH_PREFETCH_BUF_EN
    tbl[0]  = mk(1,0,0,1,16'h0000, 0,1,16'h0,16'h0);
    tbl[1]  = mk(0,0,0,1,16'h0000, 0,1,16'h0,16'h0);
    tbl[2]  = mk(0,0,0,1,16'h0000, 1,1,16'h0,16'h1);
    tbl[3]  = mk(0,0,0,1,16'h0000, 1,1,16'h1,16'h2);
    tbl[4]  = mk(0,0,0,1,16'h0000, 1,1,16'h2,16'h3);
    tbl[5]  = mk(0,0,0,1,16'h0000, 1,1,16'h3,16'h4);
    tbl[6]  = mk(0,0,0,1,16'h0000, 1,1,16'h4,16'h5);
    tbl[7]  = mk(0,1,1,0,16'h0040, 0,0,16'h0,16'h5);
    tbl[8]  = mk(0,0,1,0,16'h0080, 0,0,16'h0,16'h5);
    tbl[9]  = mk(1,0,0,1,16'h0000, 0,1,16'h0,16'h5);
    tbl[10] = mk(0,0,0,1,16'h0000, 0,1,16'h0,16'h0);
    tbl[11] = mk(0,0,0,1,16'h0000, 1,1,16'h0,16'h1);
`else
    tbl[0]  = mk(1,0,0,1,16'h0000, 0,1,16'h0,16'h0);
    tbl[1]  = mk(0,0,0,1,16'h0000, 0,1,16'h0,16'h0);
    tbl[2]  = mk(0,0,0,1,16'h0000, 1,1,16'h0,16'h0);
    tbl[3]  = mk(0,0,0,1,16'h0000, 0,1,16'h0,16'h1);
    tbl[4]  = mk(0,0,0,1,16'h0000, 1,1,16'h1,16'h1);
    tbl[5]  = mk(0,0,0,1,16'h0000, 0,1,16'h0,16'h2);
    tbl[6]  = mk(0,0,0,1,16'h0000, 1,1,16'h2,16'h2);
    tbl[7]  = mk(0,1,1,0,16'h0040, 0,0,16'h0,16'h2);
    tbl[8]  = mk(0,0,1,0,16'h0080, 0,0,16'h0,16'h2);
    tbl[9]  = mk(1,0,0,1,16'h0000, 0,1,16'h0,16'h2);
    tbl[10] = mk(0,0,0,1,16'h0000, 0,1,16'h0,16'h0);
    tbl[11] = mk(0,0,0,1,16'h0000, 1,1,16'h0,16'h0);
`endif
    for (int i = 0; i < 12; i++) begin
      start0 = tbl[i].start; halt0 = tbl[i].halt; redir0 = tbl[i].redir;
      ready0 = tbl[i].ready; rpc0 = tbl[i].rpc;
      step();
      chk($sformatf("tbl%0d_valid", i), 16'(bus0.out_valid), 16'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i),  16'(busy0),          16'(tbl[i].eb));
      chk($sformatf("tbl%0d_addr", i),  bus0.imem_addr,      tbl[i].ea);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i),    bus0.out_pc,    tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), bus0.out_instr, memf(tbl[i].epc));
      end
    end
    start0 = 0; halt0 = 0; redir0 = 0; ready0 = 0;

    // ---------------- back-pressure: hold first word, then release
    do_reset();
    start0 = 1; ready0 = 0;
    step();
    start0 = 0;
    for (int i = 0; i < 10 && !bus0.out_valid; i++) step();
    chk("stall_first_valid", 16'(bus0.out_valid), 16'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_valid", 16'(bus0.out_valid), 16'h1);
      chk("stall_hold_pc",    bus0.out_pc,    16'h0000);
      chk("stall_hold_instr", bus0.out_instr, memf(16'h0000));
    end
    chk("stall_issue_limit", bus0.imem_addr, 16'(DEPTH - 1));
    ready0 = 1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (bus0.out_valid) begin
        chk("stall_rel_pc",    bus0.out_pc,    16'(n));
        chk("stall_rel_instr", bus0.out_instr, memf(16'(n)));
        n++;
      end
      step();
    end
    chk("stall_rel_count", 16'(n), 16'd3);

    // ---------------- redirect while address 3 is in flight
    do_reset();
    start0 = 1; ready0 = 1;
    step();
    start0 = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus0.imem_addr == 16'h0003) found = 1'b1;
      else step();
    end
    chk("redir_saw_addr3", 16'(found), 16'h1);
    redir0 = 1; rpc0 = 16'h0040;
    step();
    redir0 = 0;
    chk("redir_r0_valid", 16'(bus0.out_valid), 16'h0);
    step();
    chk("redir_r1_valid", 16'(bus0.out_valid), 16'h0);
    chk("redir_r1_addr",  bus0.imem_addr, 16'h0040);
    step();
    chk("redir_r2_valid", 16'(bus0.out_valid), 16'h1);
    chk("redir_r2_pc",    bus0.out_pc,    16'h0040);
    chk("redir_r2_instr", bus0.out_instr, memf(16'h0040));

    // ---------------- reset mid-stream
    chk("midrst_pre_valid", 16'(bus0.out_valid), 16'h1);
    rst = 1'b0;
    step();
    chk("midrst_valid", 16'(bus0.out_valid), 16'h0);
    chk("midrst_instr", bus0.out_instr, 16'h0);
    chk("midrst_pc",    bus0.out_pc,    16'h0);
    chk("midrst_busy",  16'(busy0),     16'h0);
    chk("midrst_addr",  bus0.imem_addr, 16'h0000);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("midrst_idle_valid", 16'(bus0.out_valid), 16'h0);
    chk("midrst_idle_busy",  16'(busy0),          16'h0);
    chk("midrst_idle_addr",  bus0.imem_addr,      16'h0000);
    ready0 = 0;

    // ---------------- PC wrap from RESET_PC = FFFE
    exp1[0] = 16'hFFFE; exp1[1] = 16'hFFFF; exp1[2] = 16'h0000; exp1[3] = 16'h0001;
    start1 = 1; ready1 = 1;
    step();
    start1 = 0;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      if (bus1.out_valid) begin
        chk("wrap_pc",    bus1.out_pc,    exp1[n]);
        chk("wrap_instr", bus1.out_instr, memf(exp1[n]));
        n++;
      end
      step();
    end
    chk("wrap_count", 16'(n), 16'd4);
    ready1 = 0;

    // ---------------- randomized run against a stream model
    do_reset();
    begin
      logic        fetching;
      logic [15:0] exp_next;
      logic        xfer, stall, flushed, pend, old_pend, do_addr;
      logic [15:0] pend_val, old_val;
      int          idle_run;
      fetching = 0; exp_next = '0; pend = 0; pend_val = '0; idle_run = 0;
      for (int c = 0; c < 3000; c++) begin
        ready0 = ($urandom_range(0, 99) < 70);
        halt0  = ($urandom_range(0, 99) < 2);
        redir0 = ($urandom_range(0, 99) < 6);
        rpc0   = 16'($urandom);
        start0 = ($urandom_range(0, 99) < (fetching ? 5 : 30));

        xfer  = bus0.out_valid && ready0;
        stall = bus0.out_valid && !ready0;
        if (xfer) begin
          chk("rnd_pc",    bus0.out_pc,    exp_next);
          chk("rnd_instr", bus0.out_instr, memf(exp_next));
          exp_next = exp_next + 16'd1;
        end

        if (fetching && ready0 && !xfer) idle_run++;
        else idle_run = 0;

        old_pend = pend; old_val = pend_val; pend = 0;
        flushed = 0;
        if (fetching) begin
          if (halt0) begin
            fetching = 0; flushed = 1;
          end else if (redir0) begin
            exp_next = rpc0; flushed = 1; pend = 1; pend_val = rpc0;
          end
        end else if (start0) begin
          fetching = 1; exp_next = 16'h0000; pend = 1; pend_val = 16'h0000;
          idle_run = 0;
        end
        if (flushed) idle_run = 0;
        do_addr = old_pend && !flushed;

        step();
        chk("rnd_busy", 16'(busy0), 16'(fetching));
        if (!fetching) chk("rnd_idle_valid", 16'(bus0.out_valid), 16'h0);
        if (stall && !flushed) begin
          chk("rnd_hold_valid", 16'(bus0.out_valid), 16'h1);
          chk("rnd_hold_pc",    bus0.out_pc,    exp_next);
          chk("rnd_hold_instr", bus0.out_instr, memf(exp_next));
        end
        if (do_addr) chk("rnd_target_addr", bus0.imem_addr, old_val);
        if (fetching) chk("rnd_liveness", 16'(idle_run <= 8), 16'h1);
      end
    end
    start0 = 0; halt0 = 0; redir0 = 0; ready0 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
